// File: rtl/avalon_line_master_if.sv
// rtl/avalon_line_master_if.sv - Avalon-MM burst bus between the line master and its slave
interface avalon_line_master_if #(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 30
);
  localparam int BC_W = $clog2(LINE_WORDS) + 1;

  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [1:0]        avm_response;
  logic              avm_writeresponsevalid;
  logic [BC_W-1:0]   avm_burstcount;
  logic [31:0]       avm_writedata;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;

  modport master (
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, avm_response,
           avm_writeresponsevalid,
    output avm_burstcount, avm_writedata, avm_address, avm_read, avm_write,
           avm_byteenable
  );

  modport slave (
    output avm_waitrequest, avm_readdata, avm_readdatavalid, avm_response,
           avm_writeresponsevalid,
    input  avm_burstcount, avm_writedata, avm_address, avm_read, avm_write,
           avm_byteenable
  );
endinterface

// File: rtl/avalon_line_master.sv
// rtl/avalon_line_master.sv - CPU word/line request to Avalon-MM burst master.
// Optional stall abort enabled by macro AVM_TIMEOUT_EN.
module avalon_line_master #(
  parameter int LINE_WORDS     = 16,
  parameter int ADDR_W         = 30,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_strobe,
  input  logic                     req_line,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [32*LINE_WORDS-1:0] req_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [32*LINE_WORDS-1:0] resp_data,
  output logic                     err_valid,
  output logic [ADDR_W+1:0]        err_addr,
  input  logic                     err_ack,
  avalon_line_master_if.master     avm
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int BC_W  = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, WR_RESP, RESP} state_t;
  state_t state, state_nx;

  logic              cap_write;
  logic              cap_line;
  logic [3:0]        cap_strobe;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       wr_word [LINE_WORDS];
  logic [31:0]       rd_word [LINE_WORDS];
  logic [IDX_W-1:0]  beat;

  logic accept, last_beat, rd_hs, beat_in, wr_acc, wresp, new_err, tmo_hit;

  always_comb begin
    accept    = !rst && (state == IDLE) && req_valid && !err_valid;
    last_beat = !cap_line || (beat == IDX_W'(LINE_WORDS - 1));
    rd_hs     = (state == RD_CMD) && !avm.avm_waitrequest;
    // Beats that arrive while the command is still being handshaken count too.
    beat_in   = avm.avm_readdatavalid && ((state == RD_CMD) || (state == RD_DATA));
    wr_acc    = (state == WR_DATA) && !avm.avm_waitrequest;
    wresp     = (state == WR_RESP) && avm.avm_writeresponsevalid;
    new_err   = ((beat_in || wresp) && (avm.avm_response != 2'b00)) || tmo_hit;
  end

  always_comb begin
    req_ready          = accept;
    resp_valid         = !rst && (state == RESP) && resp_ready;
    avm.avm_read       = !rst && (state == RD_CMD);
    avm.avm_write      = !rst && (state == WR_DATA);
    avm.avm_address    = cap_addr;
    avm.avm_burstcount = cap_line ? BC_W'(LINE_WORDS) : BC_W'(1);
    avm.avm_byteenable = (cap_write && !cap_line) ? cap_strobe : 4'hF;
    avm.avm_writedata  = wr_word[beat];
  end

  always_comb begin
    resp_data = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      resp_data[32*i +: 32] = rd_word[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (|req_strobe) ? WR_DATA : RD_CMD;
        end
      end
      RD_CMD: begin
        if (rd_hs && beat_in && last_beat) begin
          state_nx = RESP;
        end else if (rd_hs) begin
          state_nx = RD_DATA;
        end
      end
      RD_DATA: begin
        if (beat_in && last_beat) begin
          state_nx = RESP;
        end
      end
      WR_DATA: begin
        if (wr_acc && last_beat) begin
          state_nx = WR_RESP;
        end
      end
      WR_RESP: begin
        if (wresp) begin
          state_nx = IDLE;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // An aborted read still hands back whatever beats arrived.
    if (tmo_hit) begin
      state_nx = cap_write ? IDLE : RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_write  <= 1'b0;
      cap_line   <= 1'b0;
      cap_strobe <= 4'h0;
      cap_addr   <= '0;
      beat       <= '0;
      err_valid  <= 1'b0;
      err_addr   <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        rd_word[i] <= 32'h0;
      end
    end else begin
      if (accept) begin
        cap_write  <= |req_strobe;
        cap_line   <= req_line;
        cap_strobe <= req_strobe;
        cap_addr   <= req_addr;
        beat       <= '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
          wr_word[i] <= req_data[32*i +: 32];
          rd_word[i] <= 32'h0;
        end
      end
      if (beat_in) begin
        rd_word[beat] <= avm.avm_readdata;
        beat          <= beat + 1'b1;
      end
      if (wr_acc) begin
        beat <= beat + 1'b1;
      end
      if (new_err) begin
        err_valid <= 1'b1;
        err_addr  <= {cap_addr, 2'b00};
      end else if (err_ack) begin
        err_valid <= 1'b0;
      end
    end
  end

`ifdef AVM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_live;
  logic             tmo_activity;

  always_comb begin
    tmo_live     = (state == RD_CMD) || (state == RD_DATA) ||
                   (state == WR_DATA) || (state == WR_RESP);
    tmo_activity = rd_hs || beat_in || wr_acc || wresp;
    tmo_hit      = tmo_live && !tmo_activity && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || !tmo_live || tmo_activity) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_line_master.sv
// tb/tb_avalon_line_master.sv - directed bench with transaction model for avalon_line_master
module tb_avalon_line_master;
  localparam int LW  = 16;
  localparam int AW  = 30;
  localparam int TMO = 8;
  localparam int DW  = 32 * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_line, resp_valid, resp_ready, err_valid, err_ack;
  logic [3:0]    req_strobe;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data, resp_data;
  logic [AW+1:0] err_addr;

  always #5 clk = ~clk;

  avalon_line_master_if #(.LINE_WORDS(LW), .ADDR_W(AW)) bus ();

  avalon_line_master #(.LINE_WORDS(LW), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_strobe(req_strobe), .req_line(req_line), .req_addr(req_addr),
    .req_data(req_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .err_valid(err_valid), .err_addr(err_addr),
    .err_ack(err_ack), .avm(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: what the block owes the CPU and the bus this cycle.
  bit            chk_en = 1'b0;
  bit            m_busy = 1'b0, m_wr = 1'b0, m_lreq = 1'b0, m_cmd_done = 1'b0, m_err = 1'b0;
  int            m_n = 1, m_beats = 0, m_stall = 0;
  logic [AW-1:0] m_addr = '0;
  logic [3:0]    m_strobe = 4'h0;
  logic [AW+1:0] m_err_addr = '0;
  logic [31:0]   m_wdata [LW];
  logic [31:0]   m_rline [LW];

  int            n_acc = 0, n_resp = 0, n_rd_hs = 0, n_rd_cyc = 0;
  logic [DW-1:0] last_resp = '0;
  logic [4:0]    last_rd_bc = '0, last_wr_bc = '0;
  logic [AW-1:0] last_rd_addr = '0;
  logic [3:0]    last_be = '0;
  logic [31:0]   wr_seen [$];

  bit            c_rr, c_rd, c_wr, c_rv, c_hs, c_rbeat, c_wbeat, c_wresp, c_tmo, c_err;
  logic [DW-1:0] c_line;

  always @(negedge clk) begin
    if (chk_en) begin
      c_rr = !rst && !m_busy && req_valid && !m_err;
      c_rd = !rst && m_busy && !m_wr && !m_cmd_done;
      c_wr = !rst && m_busy && m_wr && (m_beats < m_n);
      c_rv = !rst && m_busy && !m_wr && (m_beats == m_n) && resp_ready;
      chk("req_ready", req_ready, c_rr);
      chk("avm_read", bus.avm_read, c_rd);
      chk("avm_write", bus.avm_write, c_wr);
      chk("resp_valid", resp_valid, c_rv);
      chk("err_valid", err_valid, m_err);
      if (m_err) chk("err_addr", err_addr, m_err_addr);
      if (c_rd || c_wr) begin
        chk("avm_address", bus.avm_address, m_addr);
        chk("avm_burstcount", bus.avm_burstcount, m_lreq ? 5'd16 : 5'd1);
        chk("avm_byteenable", bus.avm_byteenable, (m_wr && !m_lreq) ? m_strobe : 4'hF);
      end
      if (c_wr) chk("avm_writedata", bus.avm_writedata, m_wdata[m_beats]);
      if (c_rv) begin
        for (int k = 0; k < LW; k++) c_line[32*k +: 32] = m_rline[k];
        chk("resp_data", resp_data, c_line);
      end

      if (req_valid && req_ready) n_acc++;
      if (resp_valid) begin n_resp++; last_resp = resp_data; end
      if (bus.avm_read) n_rd_cyc++;
      if (bus.avm_read && !bus.avm_waitrequest) begin
        n_rd_hs++; last_rd_bc = bus.avm_burstcount; last_rd_addr = bus.avm_address;
      end
      if (bus.avm_write && !bus.avm_waitrequest) begin
        wr_seen.push_back(bus.avm_writedata); last_be = bus.avm_byteenable;
        last_wr_bc = bus.avm_burstcount;
      end

      if (rst) begin
        m_busy = 1'b0; m_err = 1'b0; m_beats = 0; m_stall = 0; m_cmd_done = 1'b0;
      end else begin
        c_hs    = c_rd && !bus.avm_waitrequest;
        c_rbeat = m_busy && !m_wr && (m_beats < m_n) && bus.avm_readdatavalid;
        c_wbeat = c_wr && !bus.avm_waitrequest;
        c_wresp = m_busy && m_wr && (m_beats == m_n) && bus.avm_writeresponsevalid;
`ifdef AVM_TIMEOUT_EN
        if (m_busy && !(!m_wr && m_beats == m_n) && !(c_hs || c_rbeat || c_wbeat || c_wresp)) begin
          c_tmo = (m_stall == TMO - 1);
          m_stall++;
        end else begin
          c_tmo = 1'b0;
          m_stall = 0;
        end
`else
        c_tmo = 1'b0;
`endif
        c_err = ((c_rbeat || c_wresp) && bus.avm_response != 2'b00) || c_tmo;
        if (c_hs) m_cmd_done = 1'b1;
        if (c_rbeat) begin m_rline[m_beats] = bus.avm_readdata; m_beats++; end
        if (c_wbeat) m_beats++;
        if (c_wresp || c_rv) m_busy = 1'b0;
        if (c_tmo) begin
          if (m_wr) m_busy = 1'b0;
          else begin m_beats = m_n; m_cmd_done = 1'b1; end
        end
        if (c_err) begin m_err = 1'b1; m_err_addr = {m_addr, 2'b00}; end
        else if (err_ack) m_err = 1'b0;
        if (c_rr) begin
          m_busy = 1'b1; m_wr = |req_strobe; m_lreq = req_line; m_n = req_line ? LW : 1;
          m_addr = req_addr; m_strobe = req_strobe; m_beats = 0; m_cmd_done = 1'b0; m_stall = 0;
          for (int k = 0; k < LW; k++) begin
            m_wdata[k] = req_data[32*k +: 32];
            m_rline[k] = 32'h0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] s, input logic l, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    int a0;
    int i;
    a0 = n_acc;
    i  = 0;
    req_strobe = s; req_line = l; req_addr = a; req_data = d; req_valid = 1'b1;
    while (n_acc == a0 && i < 20) begin cyc(); i++; end
    req_valid = 1'b0;
    chk("accept_wait", n_acc, a0 + 1);
  endtask

  task automatic wait_resp(input string nm);
    int n0;
    int i;
    n0 = n_resp;
    i  = 0;
    while (n_resp == n0 && i < 40) begin cyc(); i++; end
    chk(nm, n_resp, n0 + 1);
  endtask

  logic [DW-1:0] exp_line;
  logic [DW-1:0] wdat;
  int            a_before;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_strobe = 4'h0; req_line = 1'b0; req_addr = '0;
    req_data = '0; resp_ready = 1'b0; err_ack = 1'b0;
    bus.avm_waitrequest = 1'b1; bus.avm_readdata = '0; bus.avm_readdatavalid = 1'b0;
    bus.avm_response = 2'b00; bus.avm_writeresponsevalid = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_err_valid", err_valid, 1'b0);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_avm_read", bus.avm_read, 1'b0);
    rst = 1'b0;
    cyc();

    // Line read at 0x100: 3 waitrequest cycles, gap before beat 6, RESP held off twice.
    for (int k = 0; k < LW; k++) wdat[32*k +: 32] = $urandom;
    issue(4'h0, 1'b1, 30'h100, wdat);
    repeat (3) cyc();
    bus.avm_waitrequest = 1'b0; cyc(); bus.avm_waitrequest = 1'b1;
    for (int k = 0; k < LW; k++) begin
      if (k == 6) begin bus.avm_readdatavalid = 1'b0; cyc(); end
      bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'hA0 + k; cyc();
    end
    bus.avm_readdatavalid = 1'b0;
    cyc(); cyc();
    chk("resp_held", n_resp, 0);
    resp_ready = 1'b1;
    wait_resp("line_read_resp");
    resp_ready = 1'b0;
    cyc();
    for (int k = 0; k < LW; k++) exp_line[32*k +: 32] = 32'hA0 + k;
    chk("line_read_data", last_resp, exp_line);
    chk("line_read_hs", n_rd_hs, 1);
    chk("line_read_bc", last_rd_bc, 5'd16);
    chk("line_read_addr", last_rd_addr, 30'h100);
    chk("line_read_pulses", n_resp, 1);

    // Single write, strobe 0011, response 5 cycles after the beat.
    wr_seen.delete();
    wdat = {DW{1'b1}};
    wdat[31:0] = 32'h1234;
    issue(4'b0011, 1'b0, 30'h55, wdat);
    bus.avm_waitrequest = 1'b0; cyc(); bus.avm_waitrequest = 1'b1;
    repeat (4) cyc();
    bus.avm_writeresponsevalid = 1'b1; cyc(); bus.avm_writeresponsevalid = 1'b0;
    cyc();
    chk("sw_beats", wr_seen.size(), 1);
    chk("sw_data", wr_seen[0], 32'h1234);
    chk("sw_be", last_be, 4'b0011);
    chk("sw_bc", last_wr_bc, 5'd1);
    chk("sw_no_resp", n_resp, 1);

    // Line write with waitrequest toggling every cycle.
    wr_seen.delete();
    for (int k = 0; k < LW; k++) wdat[32*k +: 32] = 32'hC0DE0000 + k;
    issue(4'hF, 1'b1, 30'h200, wdat);
    for (int i = 0; i < 80 && wr_seen.size() < LW; i++) begin
      bus.avm_waitrequest = ~bus.avm_waitrequest; cyc();
    end
    bus.avm_waitrequest = 1'b1; cyc();
    bus.avm_writeresponsevalid = 1'b1; cyc(); bus.avm_writeresponsevalid = 1'b0;
    cyc();
    chk("lw_beats", wr_seen.size(), LW);
    for (int k = 0; k < LW && k < wr_seen.size(); k++) chk("lw_word", wr_seen[k], 32'hC0DE0000 + k);

    // Read at 0x40 with slave error on beat 7, and error+ack together on beat 9.
    issue(4'h0, 1'b1, 30'h40, '0);
    bus.avm_waitrequest = 1'b0; cyc(); bus.avm_waitrequest = 1'b1;
    for (int k = 0; k < LW; k++) begin
      bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'hB0 + k;
      bus.avm_response = (k == 7) ? 2'b10 : ((k == 9) ? 2'b01 : 2'b00);
      err_ack = (k == 9);
      cyc();
      if (k == 7) begin
        chk("err_set", err_valid, 1'b1);
        chk("err_addr_0x100", err_addr, 32'h100);
      end
      if (k == 9) chk("err_ack_loses", err_valid, 1'b1);
    end
    bus.avm_readdatavalid = 1'b0; bus.avm_response = 2'b00; err_ack = 1'b0;
    resp_ready = 1'b1;
    wait_resp("err_read_resp");
    chk("err_read_word7", last_resp[32*7 +: 32], 32'hB7);
    a_before = n_acc;
    req_strobe = 4'h0; req_line = 1'b0; req_addr = 30'h5; req_valid = 1'b1;
    cyc(); cyc();
    chk("refused_while_err", n_acc, a_before);
    err_ack = 1'b1; cyc(); err_ack = 1'b0;
    chk("err_cleared", err_valid, 1'b0);
    issue(4'h0, 1'b0, 30'h5, '0);
    bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'hDEADBEEF;
    cyc();
    bus.avm_waitrequest = 1'b1; bus.avm_readdatavalid = 1'b0;
    wait_resp("single_read_resp");
    chk("single_read_zero_fill", last_resp, {{(DW-32){1'b0}}, 32'hDEADBEEF});

    // Reset in the middle of a line read, at beat 5, after an error on beat 2.
    issue(4'h0, 1'b1, 30'h300, '0);
    bus.avm_waitrequest = 1'b0; cyc(); bus.avm_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'hE0 + k;
      bus.avm_response = (k == 2) ? 2'b11 : 2'b00;
      cyc();
    end
    bus.avm_response = 2'b00;
    chk("pre_rst_err", err_valid, 1'b1);
    bus.avm_readdata = 32'hE5; rst = 1'b1; cyc();
    rst = 1'b0; bus.avm_readdatavalid = 1'b0;
    chk("post_rst_read", bus.avm_read, 1'b0);
    chk("post_rst_err", err_valid, 1'b0);
    chk("post_rst_data", resp_data, '0);
    bus.avm_readdatavalid = 1'b1; bus.avm_response = 2'b10; cyc();
    bus.avm_readdatavalid = 1'b0; bus.avm_response = 2'b00;
    chk("idle_beat_ignored", err_valid, 1'b0);
    issue(4'h0, 1'b0, 30'h7, '0);
    bus.avm_waitrequest = 1'b0; cyc(); bus.avm_waitrequest = 1'b1;
    cyc();
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'h600D; cyc();
    bus.avm_readdatavalid = 1'b0;
    wait_resp("fresh_read_resp");
    chk("fresh_read_data", last_resp, {{(DW-32){1'b0}}, 32'h600D});

`ifdef AVM_TIMEOUT_EN
    // Silent slave: abort after 8 stalled command cycles.
    n_rd_cyc = 0;
    issue(4'h0, 1'b1, 30'h500, '0);
    wait_resp("tmo_resp");
    chk("tmo_cmd_cycles", n_rd_cyc, 8);
    chk("tmo_err", err_valid, 1'b1);
    chk("tmo_err_addr", err_addr, 32'h1400);
    chk("tmo_zero_data", last_resp, '0);
    err_ack = 1'b1; cyc(); err_ack = 1'b0;
`endif

    resp_ready = 1'b0;
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
